// File: rtl/scan_mux_pkg.sv
// rtl/scan_mux_pkg.sv - shared state type, mode encodings and width helper for scan_mux
package scan_mux_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_MANUAL, ST_SCAN, ST_BLANK} scan_state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scan_mux_dwell_counter.sv
// rtl/scan_mux_dwell_counter.sv - wrapping 0..MAX-1 counter with clear, enable and terminal-count pulse
module dwell_counter
   import scan_mux_pkg::*;
#(
   parameter int MAX = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clr,
   input  logic                       en,
   output logic [clog2_min1(MAX)-1:0] count,
   output logic                       tc
);

   localparam int            CW   = clog2_min1(MAX);
   localparam logic [CW-1:0] LAST = CW'(MAX - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign tc    = en && !clr && (count_q == LAST);

endmodule

// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - NCH-channel registered selector with manual and round-robin scan modes
// Optional SCAN_MUX_BLANK_EN inserts one blank output cycle after every scan pointer advance.
module scan_mux
   import scan_mux_pkg::*;
#(
   parameter int WIDTH = 7,
   parameter int NCH   = 4,
   parameter int DWELL = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NCH*WIDTH-1:0]       in_data,
   input  logic                       mode,
   input  logic [clog2_min1(NCH)-1:0] sel,
   input  logic                       hold,
   output logic [WIDTH-1:0]           out,
   output logic [clog2_min1(NCH)-1:0] out_ch,
   output logic                       out_valid,
   output logic                       ch_chg,
   output logic                       sel_err
);

   localparam int              SELW     = clog2_min1(NCH);
   localparam logic [SELW-1:0] LAST_PTR = SELW'(NCH - 1);

   scan_state_t      state_q, state_d;
   logic [SELW-1:0]  ptr_q, ptr_d;
   logic [SELW-1:0]  out_ch_q, out_ch_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             chg_q, chg_d;
   logic [WIDTH-1:0] chan [NCH];
   logic [SELW-1:0]  next_ptr;
   logic             dw_clr, dw_en, dw_tc;
   logic [clog2_min1(DWELL)-1:0] dw_count_unused;

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         chan[k] = in_data[k*WIDTH +: WIDTH];
      end
   end

   // The counter only runs while scanning continues; any manual cycle leaves it at zero.
   assign dw_en    = (state_q == ST_SCAN) && (mode == MODE_SCAN) && !hold;
   assign dw_clr   = (mode == MODE_MANUAL) || (state_q == ST_IDLE) || (state_q == ST_MANUAL);
   assign next_ptr = (ptr_q == LAST_PTR) ? '0 : ptr_q + 1'b1;

   dwell_counter #(.MAX(DWELL)) u_dwell (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (dw_clr),
      .en      (dw_en),
      .count   (dw_count_unused),
      .tc      (dw_tc)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      out_d    = out_q;
      out_ch_d = out_ch_q;
      valid_d  = valid_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
         end
         ST_MANUAL: begin
            if (int'(sel) < NCH) begin
               out_d    = chan[sel];
               out_ch_d = sel;
               valid_d  = 1'b1;
               err_d    = 1'b0;
            end else begin
               out_d    = '0;
               valid_d  = 1'b0;
               err_d    = 1'b1;
            end
            if (mode == MODE_SCAN) begin
               state_d = ST_SCAN;
               ptr_d   = '0;
            end
         end
         ST_SCAN: begin
            out_d    = chan[ptr_q];
            out_ch_d = ptr_q;
            valid_d  = 1'b1;
            err_d    = 1'b0;
            if (mode == MODE_MANUAL) begin
               state_d = ST_MANUAL;
            end else if (dw_tc) begin
               ptr_d = next_ptr;
`ifdef SCAN_MUX_BLANK_EN
               state_d = ST_BLANK;
`endif
            end
         end
`ifdef SCAN_MUX_BLANK_EN
         ST_BLANK: begin
            out_d    = '0;
            out_ch_d = ptr_q;
            valid_d  = 1'b0;
            err_d    = 1'b0;
            state_d  = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign chg_d = (out_ch_d != out_ch_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         out_q    <= '0;
         out_ch_q <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         chg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         out_q    <= out_d;
         out_ch_q <= out_ch_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         chg_q    <= chg_d;
      end
   end

   assign out       = out_q;
   assign out_ch    = out_ch_q;
   assign out_valid = valid_q;
   assign ch_chg    = chg_q;
   assign sel_err   = err_q;

endmodule
